alu_pkt_sequencer: RTL and testbench

Controller that sequences the packet-buffer FIFO and the embedded processor in the ALU user datapath. Admits one packet into the shared SRAM FIFO, then blocks further input. Pulses a PC clear and runs the processor until it signals done or a watchdog expires. Releases the processed packet downstream, then re-arms. When sequencing is disabled, the block is transparent pass-through.

---
 rtl/alu_pkt_sequencer_pkg.sv | 28 ++
 rtl/alu_seq_watchdog.sv | 32 +++
 rtl/alu_pkt_sequencer.sv | 111 +++++++++++
 tb/tb_alu_pkt_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkt_sequencer_pkg.sv
// Shared definitions for the ALU packet sequencer: FSM encodings, default
// watchdog value, register field positions and a saturating counter helper.
package alu_pkt_sequencer_pkg;

    // Encodings are exported on state_out and must stay stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

    localparam int DEFAULT_TIMEOUT = 1000;

    // Software control register fields
    localparam int SW_REG_ENABLE_BIT  = 0;
    localparam int SW_REG_TIMEOUT_LSB = 16;

    // Hardware status register fields
    localparam int HW_REG_STATE_LSB     = 0;
    localparam int HW_REG_PROTO_ERR_BIT = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// Run watchdog: counts enabled cycles and pulses expire on the cycle the count reaches sw_timeout-1.
// Latency: expire is combinational from the count register; sw_timeout == 0 disables it. No backpressure.
// Backpressure: none; clr has priority over en.
module alu_seq_watchdog #(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] sw_timeout,
    output logic             expire
);
    import alu_pkt_sequencer_pkg::*;

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            timer <= '0;
        end else if (en) begin
            timer <= timer + ONE;
        end
    end

    // The final enabled cycle is the one where timer == sw_timeout-1, so an
    // enabled run lasts exactly sw_timeout cycles.
    assign expire = en && (sw_timeout != '0) && (timer == (sw_timeout - ONE));

endmodule

// File: rtl/alu_pkt_sequencer.sv
// Admits one packet into the shared FIFO, runs the processor until done or watchdog, then drains.
// Latency: all outputs decode from the registered state; input effects appear one cycle later.
// Backpressure: in_rdy_gate closes the FIFO input after EOP until drain; drain_en holds output until run ends.
module alu_pkt_sequencer #(
    parameter int CTRL_WIDTH = 8,
    parameter int TMR_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_enable,
    input  logic [TMR_W-1:0]      sw_timeout,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  fifo_empty,
    input  logic                  cpu_done,
    output logic                  in_rdy_gate,
    output logic                  drain_en,
    output logic                  pc_en,
    output logic                  pc_clr,
    output logic [31:0]           pkt_count,
    output logic [15:0]           timeout_count,
    output logic                  proto_err,
    output logic [2:0]            state_out
);
    import alu_pkt_sequencer_pkg::*;

    seq_state_t state_q, state_d;
    logic       in_payload;
    logic       eop;
    logic       wd_clr;
    logic       wd_expire;

    assign eop = in_wr && (in_ctrl != '0) && in_payload;

    // Payload words set the flag; a non-zero ctrl word either ends the packet
    // (flag set) or is a leading header (flag already clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            in_payload <= 1'b0;
        end else if (in_wr) begin
            in_payload <= (in_ctrl == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_rdy_gate = 1'b0;
        drain_en    = 1'b0;
        pc_en       = 1'b0;
        pc_clr      = 1'b0;
        wd_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy_gate = 1'b1;
                drain_en    = 1'b1;
                if (sw_enable && !in_payload && fifo_empty) state_d = ST_RECV;
            end
            ST_RECV: begin
                in_rdy_gate = 1'b1;
                if (eop) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pc_clr  = 1'b1;
                wd_clr  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_en = 1'b1;
                if (cpu_done || wd_expire) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_en = 1'b1;
                if (fifo_empty) state_d = sw_enable ? ST_RECV : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu_seq_watchdog #(.TMR_W(TMR_W)) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clr        (wd_clr),
        .en         (pc_en),
        .sw_timeout (sw_timeout),
        .expire     (wd_expire)
    );

    // cpu_done wins a same-cycle tie, so only a bare expiry counts as a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count     <= '0;
            timeout_count <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (state_q == ST_RUN && state_d == ST_DRAIN) pkt_count <= pkt_count + 32'd1;
            if (state_q == ST_RUN && wd_expire && !cpu_done) timeout_count <= sat_inc16(timeout_count);
            if (in_wr && !in_rdy_gate) proto_err <= 1'b1;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_alu_pkt_sequencer.sv
// Directed bench for alu_pkt_sequencer with a scoreboard of per-packet run expectations.
module tb_alu_pkt_sequencer;
    import alu_pkt_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_enable;
    logic [15:0] sw_timeout;
    logic        in_wr;
    logic [7:0]  in_ctrl;
    logic        fifo_empty;
    logic        cpu_done;
    logic        in_rdy_gate;
    logic        drain_en;
    logic        pc_en;
    logic        pc_clr;
    logic [31:0] pkt_count;
    logic [15:0] timeout_count;
    logic        proto_err;
    logic [2:0]  state_out;

    always #5 clk = ~clk;

    alu_pkt_sequencer #(.CTRL_WIDTH(8), .TMR_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_enable     (sw_enable),
        .sw_timeout    (sw_timeout),
        .in_wr         (in_wr),
        .in_ctrl       (in_ctrl),
        .fifo_empty    (fifo_empty),
        .cpu_done      (cpu_done),
        .in_rdy_gate   (in_rdy_gate),
        .drain_en      (drain_en),
        .pc_en         (pc_en),
        .pc_clr        (pc_clr),
        .pkt_count     (pkt_count),
        .timeout_count (timeout_count),
        .proto_err     (proto_err),
        .state_out     (state_out)
    );

    typedef struct {
        int run_cycles;
        int pkts;
        int touts;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] c);
        in_wr   = 1'b1;
        in_ctrl = c;
        tick();
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
    endtask

    // Called with the DUT in LOAD; returns with the DUT just past RUN.
    task automatic run_phase(input int done_at, input int dis_at);
        exp_t e;
        int   cycles  = 0;
        int   clr_cnt = 0;
        check("load_state", state_out, ST_LOAD);
        check("load_gate", in_rdy_gate, 1'b0);
        if (pc_clr === 1'b1) clr_cnt++;
        tick();
        while (pc_en === 1'b1 && cycles < 500) begin
            cycles++;
            if (pc_clr === 1'b1) clr_cnt++;
            if (cycles == done_at) cpu_done = 1'b1;
            if (cycles == dis_at) sw_enable = 1'b0;
            tick();
            cpu_done = 1'b0;
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check("run_cycles", cycles, e.run_cycles);
            check("pkt_count", pkt_count, e.pkts);
            check("timeout_count", timeout_count, e.touts);
        end
        check("pc_clr_cycles", clr_cnt, 1);
        check("drain_state", state_out, ST_DRAIN);
    endtask

    initial begin
        logic [7:0] pt_pkt [5];
        bit         gate_ok;
        bit         drain_ok;
        bit         pc_seen;

        pt_pkt     = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
        reset      = 1'b1;
        sw_enable  = 1'b0;
        sw_timeout = 16'd0;
        in_wr      = 1'b0;
        in_ctrl    = 8'h00;
        fifo_empty = 1'b1;
        cpu_done   = 1'b0;
        repeat (2) tick();
        check("rst_state", state_out, ST_IDLE);
        check("rst_gate", in_rdy_gate, 1'b1);
        check("rst_drain", drain_en, 1'b1);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_pc_clr", pc_clr, 1'b0);
        check("rst_pkt", pkt_count, 0);
        check("rst_tout", timeout_count, 0);
        check("rst_perr", proto_err, 1'b0);
        reset = 1'b0;

        // Pass-through
        fifo_empty = 1'b0;
        gate_ok = 1'b1; drain_ok = 1'b1; pc_seen = 1'b0;
        foreach (pt_pkt[i]) begin
            send_word(pt_pkt[i]);
            gate_ok  &= (in_rdy_gate === 1'b1);
            drain_ok &= (drain_en === 1'b1);
            pc_seen  |= (pc_en === 1'b1);
        end
        check("pt_gate", gate_ok, 1'b1);
        check("pt_drain", drain_ok, 1'b1);
        check("pt_pc_en", pc_seen, 1'b0);
        check("pt_pkt", pkt_count, 0);
        check("pt_state", state_out, ST_IDLE);

        // Normal run, cpu_done on the 20th RUN cycle
        sw_enable = 1'b1; sw_timeout = 16'd100; fifo_empty = 1'b1;
        tick();
        check("arm_state", state_out, ST_RECV);
        fifo_empty = 1'b0;
        sb.push_back('{20, 1, 0});
        send_word(8'hAA); send_word(8'hBB);
        send_word(8'h00); send_word(8'h00); send_word(8'h00);
        check("recv_state", state_out, ST_RECV);
        check("recv_gate", in_rdy_gate, 1'b1);
        send_word(8'h01);
        run_phase(20, 0);
        repeat (3) tick();
        check("drain_hold", state_out, ST_DRAIN);
        check("drain_en", drain_en, 1'b1);
        check("drain_gate", in_rdy_gate, 1'b0);
        fifo_empty = 1'b1;
        tick();
        check("rearm_state", state_out, ST_RECV);

        // Stray cpu_done outside RUN
        cpu_done = 1'b1; tick(); cpu_done = 1'b0;
        check("stray_done", state_out, ST_RECV);

        // Watchdog expiry
        sw_timeout = 16'd8; fifo_empty = 1'b0;
        sb.push_back('{8, 2, 1});
        send_word(8'h00); send_word(8'h01);
        run_phase(0, 0);
        fifo_empty = 1'b1;
        tick();
        check("wd_rearm", state_out, ST_RECV);

        // cpu_done and expiry on the same cycle
        fifo_empty = 1'b0;
        sb.push_back('{8, 3, 1});
        send_word(8'h00); send_word(8'h01);
        run_phase(8, 0);
        fifo_empty = 1'b1;
        tick();
        check("tie_rearm", state_out, ST_RECV);

        // Disable during RUN, watchdog off
        sw_timeout = 16'd0; fifo_empty = 1'b0;
        sb.push_back('{5, 4, 1});
        send_word(8'h00); send_word(8'h01);
        run_phase(5, 3);
        tick();
        check("dis_drain_hold", state_out, ST_DRAIN);
        fifo_empty = 1'b1;
        tick();
        check("dis_idle", state_out, ST_IDLE);
        check("dis_gate", in_rdy_gate, 1'b1);
        fifo_empty = 1'b0;
        pc_seen = 1'b0;
        send_word(8'hFF); pc_seen |= (pc_en === 1'b1);
        send_word(8'h00); pc_seen |= (pc_en === 1'b1);
        send_word(8'h01); pc_seen |= (pc_en === 1'b1);
        check("dis_pt_pc_en", pc_seen, 1'b0);
        check("dis_pt_state", state_out, ST_IDLE);
        check("dis_pt_pkt", pkt_count, 4);

        // Protocol error and reset during RUN
        sw_enable = 1'b1; fifo_empty = 1'b1;
        tick();
        check("err_arm", state_out, ST_RECV);
        check("err_pre", proto_err, 1'b0);
        fifo_empty = 1'b0;
        send_word(8'h00); send_word(8'h01);
        tick();
        check("err_run", pc_en, 1'b1);
        send_word(8'h00);
        check("err_set", proto_err, 1'b1);
        repeat (3) tick();
        check("err_sticky", proto_err, 1'b1);
        check("err_still_run", state_out, ST_RUN);
        reset = 1'b1;
        tick();
        check("mrst_state", state_out, ST_IDLE);
        check("mrst_pc_en", pc_en, 1'b0);
        check("mrst_gate", in_rdy_gate, 1'b1);
        check("mrst_pkt", pkt_count, 0);
        check("mrst_tout", timeout_count, 0);
        check("mrst_perr", proto_err, 1'b0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
